isp8_idec_pipe: RTL and testbench

- Registered, buffered instruction-decode stage for the isp8 core; successor to the purely combinational decoder.
- Accepts raw 18-bit instructions and their PC from fetch through a valid/ready handshake, and queues them in a parametrised FIFO.
- Decodes the FIFO head into a compact class/sub-op form and holds it in an output register under a second valid/ready handshake.
- Adds undefined-opcode detection, flush on redirect, and optional PC-relative branch targets.

---
 rtl/isp8_idec_pipe_if.sv | 36 +++
 rtl/isp8_idec_pipe.sv | 182 ++++++++++++++++++
 tb/tb_isp8_idec_pipe.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/isp8_idec_pipe_if.sv
// Handshake bundle between fetch, the isp8 decode stage and execute.
// master = fetch/execute side, slave = the decode stage itself.
interface isp8_idec_pipe_if #(
   parameter int PROM_AW = 10
);
   logic               in_valid;
   logic               in_ready;
   logic [17:0]        in_instr;
   logic [PROM_AW-1:0] in_pc;

   logic               out_valid;
   logic               out_ready;
   logic [3:0]         out_class;
   logic [2:0]         out_sub;
   logic               out_imm;
   logic [4:0]         addr_rd;
   logic [4:0]         addr_rb;
   logic [7:0]         imi_data;
   logic [PROM_AW-1:0] addr_jmp;
   logic               update_c;
   logic               update_z;
   logic               undef_op;
   logic [PROM_AW-1:0] out_pc;

   modport master (
      output in_valid, in_instr, in_pc, out_ready,
      input  in_ready, out_valid, out_class, out_sub, out_imm, addr_rd, addr_rb,
             imi_data, addr_jmp, update_c, update_z, undef_op, out_pc
   );

   modport slave (
      input  in_valid, in_instr, in_pc, out_ready,
      output in_ready, out_valid, out_class, out_sub, out_imm, addr_rd, addr_rb,
             imi_data, addr_jmp, update_c, update_z, undef_op, out_pc
   );
endinterface

// File: rtl/isp8_idec_pipe.sv
// isp8 instruction-decode stage: small instruction FIFO followed by a
// registered decode output with valid/ready on both sides.
module isp8_idec_pipe #(
   parameter int PROM_AW    = 10,
   parameter int FIFO_DEPTH = 2,
   parameter int REL_BRANCH = 0
) (
   input logic              clk,
   input logic              rst,
   input logic              flush,
   isp8_idec_pipe_if.slave  bus
);
   localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

   localparam logic [3:0] CL_ARITH   = 4'd0;
   localparam logic [3:0] CL_LOGIC   = 4'd1;
   localparam logic [3:0] CL_CMPTEST = 4'd2;
   localparam logic [3:0] CL_ROT     = 4'd3;
   localparam logic [3:0] CL_FLAG    = 4'd4;
   localparam logic [3:0] CL_IOLS    = 4'd5;
   localparam logic [3:0] CL_BRC     = 4'd6;
   localparam logic [3:0] CL_CALLC   = 4'd7;
   localparam logic [3:0] CL_UNCOND  = 4'd8;
   localparam logic [3:0] CL_UNDEF   = 4'd15;

   logic [17:0]        instr_q [FIFO_DEPTH];
   logic [PROM_AW-1:0] pc_q    [FIFO_DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic [CW-1:0]      count;
   logic               push;
   logic               pop;

   logic [17:0]        head;
   logic [PROM_AW-1:0] head_pc;
   logic [1:0]         op_p;
   logic [1:0]         op_q;
   logic [3:0]         d_class;
   logic [2:0]         d_sub;
   logic               d_imm;
   logic               d_uc;
   logic               d_uz;
   logic [PROM_AW-1:0] jmp_off;
   logic [PROM_AW-1:0] d_jmp;

   assign bus.in_ready = (count < DEPTH_C) & ~flush;
   assign push         = bus.in_valid & bus.in_ready;
   assign pop          = (count != '0) & (~bus.out_valid | bus.out_ready);

   assign head    = instr_q[rd_ptr];
   assign head_pc = pc_q[rd_ptr];
   assign op_p    = head[17:16];
   assign op_q    = head[15:14];

   always_comb begin
      d_class = CL_UNDEF;
      d_sub   = 3'd0;
      d_uc    = 1'b0;
      d_uz    = 1'b0;
      case (op_p)
         2'b00: begin
            d_class = CL_ARITH;
            d_sub   = {1'b0, op_q};
            d_uc    = 1'b1;
            d_uz    = 1'b1;
         end
         2'b01: begin
            d_class = CL_LOGIC;
            d_sub   = {1'b0, op_q};
            d_uz    = (op_q != 2'b00);
         end
         2'b10: begin
            case (op_q)
               2'b00, 2'b01: begin
                  d_class = CL_CMPTEST;
                  d_sub   = {2'b00, op_q[0]};
                  d_uc    = ~op_q[0];
                  d_uz    = 1'b1;
               end
               2'b10: begin
                  if (!head[13]) begin
                     d_class = CL_ROT;
                     d_sub   = {1'b0, head[1:0]};
                     d_uc    = head[1];
                     d_uz    = 1'b1;
                  end
               end
               default: begin
                  if (head[13]) begin
                     d_class = CL_IOLS;
                     d_sub   = head[2:0];
                  end else if (head[2:1] != 2'b11) begin
                     d_class = CL_FLAG;
                     d_sub   = head[2:0];
                  end
               end
            endcase
         end
         default: begin
            case (op_q)
               2'b00:   d_class = CL_BRC;
               2'b01:   d_class = CL_CALLC;
               2'b10:   d_class = CL_UNCOND;
               default: d_class = CL_UNDEF;
            endcase
            if (op_q != 2'b11) d_sub = {1'b0, head[13:12]};
         end
      endcase
   end

   assign d_imm = head[13] & (d_class != CL_UNDEF);

   // Narrow program spaces take the low target bits directly; wider ones
   // sign-extend the 12-bit field, which is what the low bits already are.
   generate
      if (PROM_AW > 12) begin : g_wide
         assign jmp_off = {{(PROM_AW-12){head[11]}}, head[11:0]};
      end else begin : g_narrow
         assign jmp_off = head[PROM_AW-1:0];
      end
   endgenerate

   assign d_jmp = (REL_BRANCH != 0) ? head_pc + jmp_off : jmp_off;

   always_ff @(posedge clk) begin
      if (push) begin
         instr_q[wr_ptr] <= bus.in_instr;
         pc_q[wr_ptr]    <= bus.in_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         bus.out_valid <= 1'b0;
         bus.out_class <= '0;
         bus.out_sub   <= '0;
         bus.out_imm   <= 1'b0;
         bus.addr_rd   <= '0;
         bus.addr_rb   <= '0;
         bus.imi_data  <= '0;
         bus.addr_jmp  <= '0;
         bus.update_c  <= 1'b0;
         bus.update_z  <= 1'b0;
         bus.undef_op  <= 1'b0;
         bus.out_pc    <= '0;
      end else if (flush) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         bus.out_valid <= 1'b0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) begin
            rd_ptr        <= rd_ptr + 1'b1;
            bus.out_valid <= 1'b1;
            bus.out_class <= d_class;
            bus.out_sub   <= d_sub;
            bus.out_imm   <= d_imm;
            bus.addr_rd   <= head[12:8];
            bus.addr_rb   <= head[7:3];
            bus.imi_data  <= head[7:0];
            bus.addr_jmp  <= d_jmp;
            bus.update_c  <= d_uc;
            bus.update_z  <= d_uz;
            bus.undef_op  <= (d_class == CL_UNDEF);
            bus.out_pc    <= head_pc;
         end else begin
            bus.out_valid <= bus.out_valid & ~bus.out_ready;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: tb/tb_isp8_idec_pipe.sv
// Bench for isp8_idec_pipe: absolute and PC-relative instances run in
// lockstep against a queue of independently decoded expected results.
module tb_isp8_idec_pipe;
   typedef struct {
      logic [3:0] cls;
      logic [2:0] sub;
      logic       imm;
      logic [4:0] rd;
      logic [4:0] rb;
      logic [7:0] i8;
      logic [9:0] ja;
      logic [9:0] jr;
      logic [9:0] pc;
      logic       uc;
      logic       uz;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic [17:0] in_instr;
   logic [9:0]  in_pc;
   logic        out_ready;

   int   n_chk;
   int   n_fail;
   int   m_cnt;
   bit   m_ov;
   exp_t sb[$];

   isp8_idec_pipe_if #(.PROM_AW(10)) if_a ();
   isp8_idec_pipe_if #(.PROM_AW(10)) if_r ();

   assign if_a.in_valid  = in_valid;
   assign if_a.in_instr  = in_instr;
   assign if_a.in_pc     = in_pc;
   assign if_a.out_ready = out_ready;
   assign if_r.in_valid  = in_valid;
   assign if_r.in_instr  = in_instr;
   assign if_r.in_pc     = in_pc;
   assign if_r.out_ready = out_ready;

   isp8_idec_pipe #(.PROM_AW(10), .FIFO_DEPTH(2), .REL_BRANCH(0)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .bus(if_a)
   );
   isp8_idec_pipe #(.PROM_AW(10), .FIFO_DEPTH(2), .REL_BRANCH(1)) u_dut_rel (
      .clk(clk), .rst(rst), .flush(flush), .bus(if_r)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic exp_t model(input logic [17:0] ins, input logic [9:0] pc);
      exp_t e;
      int   off;
      bit   undef;
      undef = 1'b0;
      e.rd  = ins[12:8];
      e.rb  = ins[7:3];
      e.i8  = ins[7:0];
      e.pc  = pc;
      e.imm = ins[13];
      e.sub = 3'd0;
      e.uc  = 1'b0;
      e.uz  = 1'b0;
      e.cls = 4'd0;
      e.ja  = ins[9:0];
      off   = int'(signed'(ins[11:0]));
      e.jr  = 10'((int'(pc) + off) & 1023);
      case (ins[17:16])
         2'b00: begin e.cls = 4'd0; e.sub = {1'b0, ins[15:14]}; e.uc = 1'b1; e.uz = 1'b1; end
         2'b01: begin e.cls = 4'd1; e.sub = {1'b0, ins[15:14]}; e.uz = (ins[15:14] != 2'b00); end
         2'b10: begin
            if (ins[15:14] == 2'b00) begin e.cls = 4'd2; e.sub = 3'd0; e.uc = 1'b1; e.uz = 1'b1; end
            else if (ins[15:14] == 2'b01) begin e.cls = 4'd2; e.sub = 3'd1; e.uz = 1'b1; end
            else if (ins[15:14] == 2'b10) begin
               if (ins[13]) undef = 1'b1;
               else begin
                  e.cls = 4'd3; e.sub = {1'b0, ins[1:0]}; e.uz = 1'b1;
                  e.uc  = (ins[1:0] == 2'd2) || (ins[1:0] == 2'd3);
               end
            end else if (ins[13]) begin e.cls = 4'd5; e.sub = ins[2:0]; end
            else if (ins[2:0] >= 3'd6) undef = 1'b1;
            else begin e.cls = 4'd4; e.sub = ins[2:0]; end
         end
         default: begin
            if (ins[15:14] == 2'b11) undef = 1'b1;
            else begin e.cls = 4'd6 + 4'(ins[15:14]); e.sub = {1'b0, ins[13:12]}; end
         end
      endcase
      if (undef) begin
         e.cls = 4'd15; e.imm = 1'b0; e.uc = 1'b0; e.uz = 1'b0;
      end
      return e;
   endfunction

   task automatic cmp_out(input exp_t e);
      chk("class", 32'(if_a.out_class), 32'(e.cls));
      if (e.cls != 4'd15) chk("sub", 32'(if_a.out_sub), 32'(e.sub));
      chk("imm", 32'(if_a.out_imm), 32'(e.imm));
      chk("addr_rd", 32'(if_a.addr_rd), 32'(e.rd));
      chk("addr_rb", 32'(if_a.addr_rb), 32'(e.rb));
      chk("imi_data", 32'(if_a.imi_data), 32'(e.i8));
      chk("addr_jmp_abs", 32'(if_a.addr_jmp), 32'(e.ja));
      chk("update_c", 32'(if_a.update_c), 32'(e.uc));
      chk("update_z", 32'(if_a.update_z), 32'(e.uz));
      chk("undef_op", 32'(if_a.undef_op), 32'(e.cls == 4'd15));
      chk("out_pc", 32'(if_a.out_pc), 32'(e.pc));
      chk("class_rel", 32'(if_r.out_class), 32'(e.cls));
      chk("addr_jmp_rel", 32'(if_r.addr_jmp), 32'(e.jr));
      chk("out_pc_rel", 32'(if_r.out_pc), 32'(e.pc));
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_fields"}, 32'({if_a.out_valid, if_a.out_class, if_a.out_sub, if_a.out_imm,
          if_a.addr_rd, if_a.addr_rb, if_a.imi_data, if_a.update_c, if_a.update_z,
          if_a.undef_op}), 32'd0);
      chk({tag, "_jmp_pc"}, 32'({if_a.addr_jmp, if_a.out_pc}), 32'd0);
      chk({tag, "_rel"}, 32'({if_r.out_valid, if_r.out_class, if_r.undef_op,
          if_r.addr_jmp, if_r.out_pc}), 32'd0);
      chk({tag, "_in_ready"}, 32'(if_a.in_ready), 32'd1);
   endtask

   // Cycle model of occupancy and the scoreboard, evaluated mid-cycle for the coming edge.
   initial begin
      bit exp_rdy;
      bit push;
      bit pop;
      m_cnt = 0;
      m_ov  = 1'b0;
      forever begin
         @(negedge clk);
         exp_rdy = (m_cnt < 2) && !flush;
         chk("in_ready", 32'(if_a.in_ready), 32'(exp_rdy));
         chk("in_ready_rel", 32'(if_r.in_ready), 32'(exp_rdy));
         chk("out_valid", 32'(if_a.out_valid), 32'(m_ov));
         chk("out_valid_rel", 32'(if_r.out_valid), 32'(m_ov));
         if (rst || flush) begin
            sb.delete();
            m_cnt = 0;
            m_ov  = 1'b0;
         end else begin
            push = in_valid && exp_rdy;
            pop  = (m_cnt != 0) && (!m_ov || out_ready);
            if (m_ov && out_ready) begin
               if (sb.size() == 0) chk("spurious_out", 32'd1, 32'd0);
               else cmp_out(sb.pop_front());
            end
            if (push) sb.push_back(model(in_instr, in_pc));
            m_cnt = m_cnt + int'(push) - int'(pop);
            m_ov  = pop || (m_ov && !out_ready);
         end
      end
   end

   task automatic send(input logic [17:0] ins, input logic [9:0] pc, input bit rnd);
      bit acc;
      int n;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = pc;
      n        = 0;
      forever begin
         if (rnd) out_ready = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         acc = if_a.in_ready;
         @(posedge clk);
         #1;
         if (acc) break;
         n++;
         if (n > 50) begin
            chk("send_timeout", 32'd0, 32'd1);
            break;
         end
      end
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      n_chk     = 0;
      n_fail    = 0;
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = '0;
      in_pc     = '0;
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_zero("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // single subc: accepted at edge E, presented after E+1
      send(18'h0_4105, 10'h005, 1'b0);
      in_valid = 1'b0;
      @(negedge clk);
      chk("lat_e", 32'(if_a.out_valid), 32'd0);
      @(negedge clk);
      chk("lat_e1", 32'(if_a.out_valid), 32'd1);
      chk("subc_sub", 32'(if_a.out_sub), 32'd1);
      idle(2);

      // back-pressure: three fit (output + 2 queued), the fourth waits
      out_ready = 1'b0;
      send(18'h1_4210, 10'h010, 1'b0);
      send(18'h1_8318, 10'h011, 1'b0);
      send(18'h1_C420, 10'h012, 1'b0);
      in_instr = 18'h1_0528;
      in_pc    = 10'h013;
      repeat (3) begin
         @(negedge clk);
         chk("full_block", 32'(if_a.in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      send(18'h1_0528, 10'h013, 1'b0);
      idle(6);

      // undefined encodings, IOLS lspi, and a relative branch wrapping below zero
      send(18'h3_C000, 10'h020, 1'b0);
      send(18'h2_E007, 10'h021, 1'b0);
      send(18'h2_C007, 10'h022, 1'b0);
      send(18'h2_A000, 10'h023, 1'b0);
      send(18'h3_BFFE, 10'h001, 1'b0);
      send(18'h2_8003, 10'h024, 1'b0);
      send(18'h2_0000, 10'h025, 1'b0);
      idle(6);

      // random instructions under random back-pressure
      for (int i = 0; i < 60; i++)
         send(18'($urandom_range(0, 18'h3FFFF)), 10'($urandom_range(0, 1023)), 1'b1);
      out_ready = 1'b1;
      idle(8);

      // flush with a full queue and valid output; the flush-cycle instruction is dropped
      out_ready = 1'b0;
      send(18'h0_1111, 10'h030, 1'b0);
      send(18'h0_2222, 10'h031, 1'b0);
      send(18'h0_3333, 10'h032, 1'b0);
      flush    = 1'b1;
      in_instr = 18'h0_0BAD;
      in_pc    = 10'h0FF;
      @(posedge clk);
      #1;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", 32'(if_a.out_valid), 32'd0);
      chk("flush_ready", 32'(if_a.in_ready), 32'd1);
      out_ready = 1'b1;
      idle(4);
      send(18'h0_C444, 10'h040, 1'b0);
      idle(4);

      // reset mid-stream
      out_ready = 1'b0;
      send(18'h0_5555, 10'h050, 1'b0);
      send(18'h3_8666, 10'h051, 1'b0);
      rst      = 1'b1;
      in_instr = 18'h0_0777;
      in_pc    = 10'h052;
      @(posedge clk);
      #1;
      rst      = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk_zero("midrst");
      out_ready = 1'b1;
      idle(3);
      send(18'h3_4123, 10'h060, 1'b0);
      send(18'h2_7E01, 10'h061, 1'b0);
      idle(2);

      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      chk("drain_empty", 32'(sb.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end
endmodule
